// File: rtl/deadlock_mon_pkg.sv
// rtl/deadlock_mon_pkg.sv - shared state encoding and width helper for the AXI-Stream deadlock monitor
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    WARM    = 2'd0,
    ARMED   = 2'd1,
    COUNT   = 2'd2,
    LATCHED = 2'd3
  } dlm_state_t;

  // Ceiling log2 that never returns less than 1, so vectors never collapse to zero width.
  function automatic int dlm_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dlm_port_encoder.sv
// rtl/dlm_port_encoder.sv - lowest-set-index and popcount of the per-port blocked vector
module dlm_port_encoder
  import deadlock_mon_pkg::*;
#(
  parameter int NUM_AXIS = 2,
  parameter int IDX_W    = dlm_clog2(NUM_AXIS),
  parameter int CNT_W    = dlm_clog2(NUM_AXIS + 1)
) (
  input  logic [NUM_AXIS-1:0] i_vec,
  output logic [IDX_W-1:0]    o_first,
  output logic [CNT_W-1:0]    o_count
);

  // Scan downward so the last hit written is the lowest index.
  always_comb begin
    o_first = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_first = IDX_W'(i);
      end
    end
  end

  always_comb begin
    o_count = '0;
    for (int i = 0; i < NUM_AXIS; i++) begin
      o_count = o_count + CNT_W'(i_vec[i]);
    end
  end

endmodule

// File: rtl/axis_deadlock_monitor.sv
// rtl/axis_deadlock_monitor.sv - qualifies persistent stream stalls and latches a blocked-port snapshot
module axis_deadlock_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int                NUM_AXIS      = 2,
  parameter int                NUM_INST      = 1,
  parameter logic [NUM_AXIS-1:0] AXIS_IS_INPUT = 2'b01,
  parameter int                WARMUP        = 10,
  parameter int                THRESH        = 2,
  parameter int                STICKY        = 1
) (
  input  logic                                kernel_monitor_clock,
  input  logic                                kernel_monitor_reset,
  input  logic [NUM_AXIS-1:0]                 axis_blk_n,
  input  logic [NUM_INST-1:0]                 inst_idle,
  input  logic [NUM_INST-1:0]                 inst_block,
  output logic                                block,
  output logic                                block_pulse,
  output logic [NUM_AXIS-1:0]                 blocked_snap,
  output logic [dlm_clog2(NUM_AXIS)-1:0]      first_port,
  output logic [dlm_clog2(NUM_AXIS+1)-1:0]    blocked_count,
  output logic [NUM_AXIS-1:0]                 port_is_input
);

  localparam int IDX_W     = dlm_clog2(NUM_AXIS);
  localparam int CNT_W     = dlm_clog2(NUM_AXIS + 1);
  localparam int STL_W     = dlm_clog2(THRESH + 1);
  // The warm-up counter leaves WARM when its incremented value reaches WARMUP-1;
  // tiny WARMUP values collapse to a single ignored edge.
  localparam int WARM_LAST = (WARMUP > 1) ? (WARMUP - 1) : 1;
  localparam int WRM_W     = dlm_clog2(WARM_LAST + 1);

  dlm_state_t        r_state;
  dlm_state_t        w_next_state;
  logic [WRM_W-1:0]  r_warm_cnt;
  logic [WRM_W-1:0]  w_warm_cnt_next;
  logic [STL_W-1:0]  r_stall_cnt;
  logic [STL_W-1:0]  w_stall_cnt_next;
  logic              r_block;
  logic              r_block_pulse;
  logic [NUM_AXIS-1:0] r_snap;
  logic [IDX_W-1:0]  r_first;
  logic [CNT_W-1:0]  r_count;

  logic [NUM_AXIS-1:0] w_axis_block;
  logic              w_stall;
  logic              w_declare;
  logic              w_clear;
  logic [IDX_W-1:0]  w_enc_first;
  logic [CNT_W-1:0]  w_enc_count;

  assign w_axis_block = ~axis_blk_n;
  // A stall needs a blocked port and no instance still doing useful work.
  assign w_stall = (|w_axis_block) & ~(|(~inst_idle & ~inst_block));

  dlm_port_encoder #(
    .NUM_AXIS (NUM_AXIS),
    .IDX_W    (IDX_W),
    .CNT_W    (CNT_W)
  ) u_port_encoder (
    .i_vec   (w_axis_block),
    .o_first (w_enc_first),
    .o_count (w_enc_count)
  );

  always_comb begin
    w_next_state     = r_state;
    w_warm_cnt_next  = r_warm_cnt;
    w_stall_cnt_next = r_stall_cnt;
    w_declare        = 1'b0;
    w_clear          = 1'b0;
    case (r_state)
      WARM: begin
        if (int'(r_warm_cnt) + 1 >= WARM_LAST) begin
          w_next_state    = ARMED;
          w_warm_cnt_next = '0;
        end else begin
          w_warm_cnt_next = r_warm_cnt + WRM_W'(1);
        end
      end
      ARMED: begin
        if (w_stall) begin
          if (THRESH <= 1) begin
            w_declare    = 1'b1;
            w_next_state = LATCHED;
          end else begin
            w_stall_cnt_next = STL_W'(1);
            w_next_state     = COUNT;
          end
        end
      end
      COUNT: begin
        if (w_stall) begin
          if (int'(r_stall_cnt) + 1 >= THRESH) begin
            w_declare        = 1'b1;
            w_stall_cnt_next = '0;
            w_next_state     = LATCHED;
          end else begin
            w_stall_cnt_next = r_stall_cnt + STL_W'(1);
          end
        end else begin
          w_stall_cnt_next = '0;
          w_next_state     = ARMED;
        end
      end
      LATCHED: begin
        if ((STICKY == 0) && !w_stall) begin
          w_clear      = 1'b1;
          w_next_state = ARMED;
        end
      end
      default: begin
        w_next_state = WARM;
      end
    endcase
  end

  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      r_state       <= WARM;
      r_warm_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_block       <= 1'b0;
      r_block_pulse <= 1'b0;
      r_snap        <= '0;
      r_first       <= '0;
      r_count       <= '0;
    end else begin
      r_state       <= w_next_state;
      r_warm_cnt    <= w_warm_cnt_next;
      r_stall_cnt   <= w_stall_cnt_next;
      r_block_pulse <= w_declare;
      if (w_declare) begin
        r_block <= 1'b1;
        r_snap  <= w_axis_block;
        r_first <= w_enc_first;
        r_count <= w_enc_count;
      end else if (w_clear) begin
        r_block <= 1'b0;
      end
    end
  end

  assign block         = r_block;
  assign block_pulse   = r_block_pulse;
  assign blocked_snap  = r_snap;
  assign first_port    = r_first;
  assign blocked_count = r_count;
  assign port_is_input = AXIS_IS_INPUT;

endmodule
